// File: rtl/tinymips_loader.sv
// Boot loader: byte stream -> big-endian 16-bit words written to blram from address 0, then releases the CPU.
// Define TINYMIPS_LOADER_CHECKSUM_EN to require an XOR trailer byte after the last word.
module tinymips_loader #(
  parameter int SIZE  = 8,
  parameter int DEPTH = 2**SIZE
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [7:0]      byte_in,
  input  logic            byte_valid,
  output logic            byte_ready,
  output logic            wrEn,
  output logic [SIZE-1:0] addr_toRAM,
  output logic [15:0]     data_toRAM,
  output logic            mem_sel,
  output logic            cpu_rst,
  output logic            done,
  output logic            err
);

  typedef enum logic [2:0] {
    IDLE, HDR_HI, HDR_LO, DATA_HI, DATA_LO,
`ifdef TINYMIPS_LOADER_CHECKSUM_EN
    CHK,
`endif
    RUN, ERR
  } state_t;

  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  state_t        state;
  logic [15:0]   wordCnt;
  logic [SIZE:0] addrCnt;
  logic [7:0]    hiByte;
  logic [7:0]    csum;

  logic        hs;
  logic [16:0] hdrN;
  logic        lastWord;
  logic        canStart;

  assign hs       = byte_valid & byte_ready;
  assign hdrN     = {1'b0, wordCnt[15:8], byte_in};
  // addrCnt is one bit wider than the RAM address so a full-DEPTH program ends cleanly.
  assign lastWord = (17'(addrCnt) + 17'd1) == {1'b0, wordCnt};
  assign canStart = start && (state == IDLE || state == RUN || state == ERR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      byte_ready <= 1'b0;
      wrEn       <= 1'b0;
      addr_toRAM <= '0;
      data_toRAM <= '0;
      mem_sel    <= 1'b1;
      cpu_rst    <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
      wordCnt    <= '0;
      addrCnt    <= '0;
      hiByte     <= '0;
      csum       <= '0;
    end else begin
      wrEn <= 1'b0;
      if (canStart) begin
        state      <= HDR_HI;
        byte_ready <= 1'b1;
        addrCnt    <= '0;
        csum       <= '0;
        mem_sel    <= 1'b1;
        cpu_rst    <= 1'b1;
        done       <= 1'b0;
        err        <= 1'b0;
      end else begin
        case (state)
          HDR_HI: if (hs) begin
            wordCnt[15:8] <= byte_in;
            state         <= HDR_LO;
          end
          HDR_LO: if (hs) begin
            wordCnt[7:0] <= byte_in;
            if (hdrN == 17'd0 || hdrN > DEPTH_L) begin
              state      <= ERR;
              err        <= 1'b1;
              byte_ready <= 1'b0;
            end else begin
              state <= DATA_HI;
            end
          end
          DATA_HI: if (hs) begin
            hiByte <= byte_in;
            csum   <= csum ^ byte_in;
            state  <= DATA_LO;
          end
          DATA_LO: if (hs) begin
            wrEn       <= 1'b1;
            data_toRAM <= {hiByte, byte_in};
            addr_toRAM <= addrCnt[SIZE-1:0];
            addrCnt    <= addrCnt + 1'b1;
            csum       <= csum ^ byte_in;
            if (lastWord) begin
`ifdef TINYMIPS_LOADER_CHECKSUM_EN
              state <= CHK;
`else
              state      <= RUN;
              byte_ready <= 1'b0;
`endif
            end else begin
              state <= DATA_HI;
            end
          end
`ifdef TINYMIPS_LOADER_CHECKSUM_EN
          CHK: if (hs) begin
            byte_ready <= 1'b0;
            if (byte_in == csum) begin
              state <= RUN;
            end else begin
              state <= ERR;
              err   <= 1'b1;
            end
          end
`endif
          // Release happens one cycle after entry, so the final write lands while the loader still owns RAM.
          RUN: begin
            byte_ready <= 1'b0;
            mem_sel    <= 1'b0;
            cpu_rst    <= 1'b0;
            done       <= 1'b1;
          end
          ERR: begin
            byte_ready <= 1'b0;
            err        <= 1'b1;
            cpu_rst    <= 1'b1;
            mem_sel    <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
